// File: rtl/move_entry.sv
// Cursor-driven move entry: turns button levels into a 9x9 cursor and a one-cycle move strobe.
// Optional autorepeat on held direction buttons when MOVE_ENTRY_REPEAT_EN is defined.
module move_entry #(
  parameter int SETTLE_CYC  = 2,
  parameter int REPEAT_DLY  = 25_000_000,
  parameter int REPEAT_RATE = 5_000_000
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_place,
  input  logic                   btn_pass,
  input  logic [8:0][8:0][1:0]   board,
  output logic [7:0]             move,
  output logic                   move_avail,
  output logic [3:0]             cursor_row,
  output logic [3:0]             cursor_col,
  output logic [1:0]             turn,
  output logic                   reject,
  output logic                   game_over
);

  localparam logic [15:0] HOLD_LAST = (SETTLE_CYC > 1) ? 16'(SETTLE_CYC - 1) : 16'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_REJECT,
    S_HOLDOFF
  } state_t;

  state_t      state, state_d;
  logic [7:0]  move_d;
  logic        avail_d;
  logic        reject_d;
  logic        latch;
  logic [3:0]  lat_row, lat_col;
  logic [15:0] hold_cnt;
  logic [1:0]  pass_cnt;

  // Bit order: 0 place, 1 pass, 2 up, 3 down, 4 left, 5 right
  logic [5:0] btn_lvl, btn_prev, btn_edge;
  logic [3:0] dir_step;

  assign btn_lvl  = {btn_right, btn_left, btn_down, btn_up, btn_pass, btn_place};
  assign btn_edge = btn_lvl & ~btn_prev;

  always_ff @(posedge clk_in) begin
    if (reset) btn_prev <= '0;
    else       btn_prev <= btn_lvl;
  end

`ifdef MOVE_ENTRY_REPEAT_EN
  localparam logic [25:0] DLY_LAST  = 26'(REPEAT_DLY - 1);
  localparam logic [25:0] RATE_LAST = 26'(REPEAT_RATE - 1);

  logic [25:0] rep_cnt;
  logic        rep_phase;
  logic        rep_restart;
  logic        rep_fire;
  logic [3:0]  dir_held;

  // One shared counter: any change on a direction line starts the delay over.
  assign dir_held    = btn_lvl[5:2] & btn_prev[5:2];
  assign rep_restart = (|(btn_lvl[5:2] ^ btn_prev[5:2])) || (dir_held == 4'b0000);
  assign rep_fire    = !rep_restart && (rep_cnt == (rep_phase ? RATE_LAST : DLY_LAST));
  assign dir_step    = btn_edge[5:2] | (rep_fire ? dir_held : 4'b0000);

  always_ff @(posedge clk_in) begin
    if (reset || rep_restart) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b1;
    end else begin
      rep_cnt   <= rep_cnt + 26'd1;
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DLY > 0) ^ (REPEAT_RATE > 0);
  assign dir_step          = btn_edge[5:2];
`endif

  // A place or pass edge claims the cycle, so no cursor step alongside it.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cursor_row <= 4'd4;
      cursor_col <= 4'd4;
    end else if (!(btn_edge[0] || btn_edge[1])) begin
      if (dir_step[0]) begin
        if (cursor_row != 4'd0) cursor_row <= cursor_row - 4'd1;
      end else if (dir_step[1]) begin
        if (cursor_row != 4'd8) cursor_row <= cursor_row + 4'd1;
      end else if (dir_step[2]) begin
        if (cursor_col != 4'd0) cursor_col <= cursor_col - 4'd1;
      end else if (dir_step[3]) begin
        if (cursor_col != 4'd8) cursor_col <= cursor_col + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= S_IDLE;
      move       <= 8'h00;
      move_avail <= 1'b0;
      reject     <= 1'b0;
    end else begin
      state      <= state_d;
      move       <= move_d;
      move_avail <= avail_d;
      reject     <= reject_d;
    end
  end

  always_comb begin
    state_d  = state;
    move_d   = move;
    avail_d  = 1'b0;
    reject_d = 1'b0;
    latch    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!game_over) begin
          if (btn_edge[0]) begin
            latch   = 1'b1;
            state_d = S_CHECK;
          end else if (btn_edge[1]) begin
            move_d  = 8'hFF;
            avail_d = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_CHECK: begin
        if (board[lat_row][lat_col] != 2'b00) begin
          reject_d = 1'b1;
          state_d  = S_REJECT;
        end else begin
          move_d   = {lat_row, lat_col};
          avail_d  = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE:   state_d = S_HOLDOFF;
      S_REJECT:  state_d = S_IDLE;
      S_HOLDOFF: if (hold_cnt == HOLD_LAST) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (latch) begin
      lat_row <= cursor_row;
      lat_col <= cursor_col;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset || state != S_HOLDOFF) hold_cnt <= '0;
    else                             hold_cnt <= hold_cnt + 16'd1;
  end

  // 8'hFF can only come from a pass; a placement row never exceeds 8.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      turn      <= 2'b01;
      pass_cnt  <= 2'd0;
      game_over <= 1'b0;
    end else if (state == S_ISSUE) begin
      turn <= (turn == 2'b01) ? 2'b10 : 2'b01;
      if (move == 8'hFF) begin
        if (pass_cnt != 2'd2) pass_cnt <= pass_cnt + 2'd1;
        if (pass_cnt != 2'd0) game_over <= 1'b1;
      end else begin
        pass_cnt <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_move_entry.sv
// Bench for move_entry: cursor vector table, scoreboard on move/reject strobes, hand-written corner sequences.
module tb_move_entry;

  logic                 clk_in = 1'b0;
  logic                 reset;
  logic [5:0]           btns;
  logic                 btn_up, btn_down, btn_left, btn_right, btn_place, btn_pass;
  logic [8:0][8:0][1:0] board;
  logic [7:0]           move;
  logic                 move_avail;
  logic [3:0]           cursor_row, cursor_col;
  logic [1:0]           turn;
  logic                 reject, game_over;

  localparam logic [5:0] B_PLACE = 6'h01, B_PASS = 6'h02, B_UP = 6'h04,
                         B_DOWN  = 6'h08, B_LEFT = 6'h10, B_RIGHT = 6'h20;

  assign {btn_right, btn_left, btn_down, btn_up, btn_pass, btn_place} = btns;

  move_entry #(.SETTLE_CYC(2), .REPEAT_DLY(10), .REPEAT_RATE(4)) dut (
    .clk_in(clk_in), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_place(btn_place), .btn_pass(btn_pass), .board(board),
    .move(move), .move_avail(move_avail), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .turn(turn), .reject(reject), .game_over(game_over)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;
  logic [1:0] exp_turn;

  typedef struct { logic [7:0] mv; int cyc; } exp_t;
  exp_t exp_q[$];
  int   rej_q[$];

  typedef struct { logic [5:0] b; int row; int col; } cur_vec_t;
  cur_vec_t cv [38];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic press(input logic [5:0] m);
    btns = m;
    tick();
    btns = '0;
    tick();
  endtask

  task automatic flip_turn();
    exp_turn = (exp_turn == 2'b01) ? 2'b10 : 2'b01;
  endtask

  task automatic do_place(input logic [5:0] m, input logic [7:0] mv);
    exp_q.push_back('{mv, cyc + 2});
    btns = m;
    tick();
    btns = '0;
    tick();
    chk("turn_before_place_flip", int'(turn), int'(exp_turn));
    tick();
    flip_turn();
    chk("turn_after_place", int'(turn), int'(exp_turn));
    tick();
    tick();
  endtask

  task automatic do_pass();
    exp_q.push_back('{8'hFF, cyc + 1});
    btns = B_PASS;
    tick();
    btns = '0;
    chk("turn_before_pass_flip", int'(turn), int'(exp_turn));
    tick();
    flip_turn();
    chk("turn_after_pass", int'(turn), int'(exp_turn));
    tick();
    tick();
  endtask

  task automatic do_reject();
    rej_q.push_back(cyc + 2);
    btns = B_PLACE;
    tick();
    btns = '0;
    tick();
    tick();
    chk("turn_after_reject", int'(turn), int'(exp_turn));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cursor_row"}, int'(cursor_row), 4);
    chk({tag, "_cursor_col"}, int'(cursor_col), 4);
    chk({tag, "_turn"}, int'(turn), 1);
    chk({tag, "_move"}, int'(move), 0);
    chk({tag, "_move_avail"}, int'(move_avail), 0);
    chk({tag, "_reject"}, int'(reject), 0);
    chk({tag, "_game_over"}, int'(game_over), 0);
  endtask

  // Strobe scoreboard: every cycle either an expected strobe or silence.
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        chk("move_avail_strobe", int'(move_avail), 1);
        chk("move_value", int'(move), int'(exp_q[0].mv));
        void'(exp_q.pop_front());
      end else begin
        chk("move_avail_quiet", int'(move_avail), 0);
      end
      if (rej_q.size() > 0 && rej_q[0] == cyc) begin
        chk("reject_strobe", int'(reject), 1);
        void'(rej_q.pop_front());
      end else begin
        chk("reject_quiet", int'(reject), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    cv = '{
      '{B_RIGHT,4,5}, '{B_RIGHT,4,6}, '{B_RIGHT,4,7}, '{B_RIGHT,4,8}, '{B_RIGHT,4,8}, '{B_RIGHT,4,8}, '{B_RIGHT,4,8},
      '{B_UP,3,8}, '{B_UP,2,8}, '{B_UP,1,8}, '{B_UP,0,8}, '{B_UP,0,8},
      '{B_LEFT,0,7},
      '{B_DOWN,1,7}, '{B_DOWN,2,7}, '{B_DOWN,3,7}, '{B_DOWN,4,7},
      '{B_LEFT,4,6}, '{B_LEFT,4,5}, '{B_LEFT,4,4},
      '{B_DOWN,5,4}, '{B_DOWN,6,4}, '{B_DOWN,7,4}, '{B_DOWN,8,4}, '{B_DOWN,8,4},
      '{B_LEFT,8,3}, '{B_LEFT,8,2}, '{B_LEFT,8,1}, '{B_LEFT,8,0}, '{B_LEFT,8,0},
      '{B_UP,7,0}, '{B_UP,6,0}, '{B_UP,5,0}, '{B_UP,4,0},
      '{B_RIGHT,4,1}, '{B_RIGHT,4,2}, '{B_RIGHT,4,3}, '{B_RIGHT,4,4}
    };
    reset    = 1'b1;
    btns     = '0;
    board    = '0;
    exp_turn = 2'b01;
    repeat (3) tick();
    chk_reset_outputs("reset");
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();

    // Cursor stepping and saturation at every edge of the board
    for (int i = 0; i < 38; i++) begin
      press(cv[i].b);
      chk($sformatf("cursor_row_v%0d", i), int'(cursor_row), cv[i].row);
      chk($sformatf("cursor_col_v%0d", i), int'(cursor_col), cv[i].col);
    end

    // Placement on empty (4,4), place edge dropped in last holdoff cycle, pass on the first idle cycle
    begin
      int n;
      n = cyc;
      exp_q.push_back('{8'h44, n + 2});
      btns = B_PLACE;
      tick();
      btns = '0;
      tick();
      chk("turn_hold_n2", int'(turn), 1);
      tick();
      chk("turn_flip_n3", int'(turn), 2);
      exp_turn = 2'b10;
      tick();
      btns = B_PLACE;
      tick();
      btns = B_PASS;
      exp_q.push_back('{8'hFF, n + 6});
      tick();
      btns = '0;
      tick();
      chk("turn_after_holdoff_pass", int'(turn), 1);
      exp_turn = 2'b01;
      tick();
      tick();
    end

    // Occupied cell rejected
    board[4][4] = 2'b01;
    do_reject();
    chk("game_over_after_reject", int'(game_over), 0);

    // Place and up together: placement at old cursor, no step
    press(B_RIGHT);
    do_place(B_PLACE | B_UP, 8'h45);
    chk("simul_cursor_row", int'(cursor_row), 4);
    chk("simul_cursor_col", int'(cursor_col), 5);

    // Reset while in CHECK
    btns = B_PLACE;
    tick();
    btns  = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_turn = 2'b01;
    chk_reset_outputs("reset_in_check");
    tick();
    tick();

    // Pass counter: pass, place, pass keeps game running; second consecutive pass ends it
    press(B_RIGHT);
    do_pass();
    do_place(B_PLACE, 8'h45);
    do_pass();
    chk("game_over_pass_place_pass", int'(game_over), 0);
    do_pass();
    chk("game_over_two_passes", int'(game_over), 1);
    press(B_PLACE);
    tick();
    tick();
    press(B_PASS);
    tick();
    tick();
    chk("game_over_sticky", int'(game_over), 1);
    chk("turn_frozen_after_game_over", int'(turn), int'(exp_turn));
    press(B_RIGHT);
    chk("cursor_moves_in_game_over", int'(cursor_col), 6);

`ifdef MOVE_ENTRY_REPEAT_EN
    // Autorepeat: hold down from (0,0) for 20 cycles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_turn = 2'b01;
    tick();
    repeat (4) press(B_UP);
    repeat (4) press(B_LEFT);
    chk("repeat_start_row", int'(cursor_row), 0);
    chk("repeat_start_col", int'(cursor_col), 0);
    btns = B_DOWN;
    for (int k = 1; k <= 19; k++) begin
      tick();
      chk($sformatf("repeat_row_k%0d", k), int'(cursor_row),
          1 + int'(k >= 11) + int'(k >= 15) + int'(k >= 19));
    end
    tick();
    btns = '0;
    tick();
    tick();
    chk("repeat_final_row", int'(cursor_row), 4);
`endif

    repeat (4) tick();
    chk("pending_moves", exp_q.size(), 0);
    chk("pending_rejects", rej_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
